synaptic_weight_accumulator: RTL and testbench

//  Upstream feeder of the conductance LIF neuron unit. Collects synaptic weight events for one

---
 rtl/synaptic_weight_accumulator.sv | 151 +++++++++++++++
 tb/tb_synaptic_weight_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_weight_accumulator.sv
// Per-neuron excitatory/inhibitory weight accumulator for one timestep,
// drained entry by entry to the neuron update stage over valid/ready.
module synaptic_weight_accumulator #(
  parameter int INTEGER_WIDTH     = 32,
  parameter int DATA_WIDTH_FRAC   = 32,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_COUNT      = 4,
  parameter int NEURON_ADDR_WIDTH = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         SynValid,
  output logic                         SynReady,
  input  logic [NEURON_ADDR_WIDTH-1:0] SynNeuronAddr,
  input  logic                         SynInhibitory,
  input  logic [DATA_WIDTH-1:0]        SynWeight,
  input  logic                         StepStart,
  output logic                         SumValid,
  input  logic                         SumReady,
  output logic [NEURON_ADDR_WIDTH-1:0] SumNeuronAddr,
  output logic [DATA_WIDTH-1:0]        ExWeightSum,
  output logic [DATA_WIDTH-1:0]        InWeightSum,
  output logic                         StepDone
);

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  localparam logic [NEURON_ADDR_WIDTH:0] ADDR_LIMIT =
    (NEURON_ADDR_WIDTH+1)'(NEURON_COUNT);
  localparam logic [NEURON_ADDR_WIDTH-1:0] LAST_IDX =
    NEURON_ADDR_WIDTH'(NEURON_COUNT - 1);

  state_t state;
  state_t state_nx;

  logic [NEURON_ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]        ex_bank [NEURON_COUNT];
  logic [DATA_WIDTH-1:0]        in_bank [NEURON_COUNT];

  logic                  syn_fire;
  logic                  sum_fire;
  logic                  addr_ok;
  logic [DATA_WIDTH-1:0] cur;
  logic [DATA_WIDTH-1:0] upd;

  // One guard bit detects overflow; clamp to the signed extremes.
  function automatic logic [DATA_WIDTH-1:0] sat_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      if (s[DATA_WIDTH])
        return {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
        return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return s[DATA_WIDTH-1:0];
  endfunction

  assign SynReady = (state == ACCUM);
  assign SumValid = (state == DRAIN);
  assign StepDone = (state == DONE);
  assign syn_fire = SynValid & SynReady;
  assign sum_fire = SumValid & SumReady;
  assign addr_ok  = {1'b0, SynNeuronAddr} < ADDR_LIMIT;

  always_comb begin
    cur = '0;
    if (addr_ok) begin
      if (SynInhibitory)
        cur = in_bank[SynNeuronAddr];
      else
        cur = ex_bank[SynNeuronAddr];
    end
    upd = sat_add(cur, SynWeight);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      state <= ACCUM;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: begin
        if (StepStart)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (sum_fire && idx == LAST_IDX)
          state_nx = DONE;
      end
      DONE: begin
        state_nx = ACCUM;
      end
      default: begin
        state_nx = ACCUM;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      idx <= '0;
    else if (sum_fire) begin
      if (idx == LAST_IDX)
        idx <= '0;
      else
        idx <= idx + 1'b1;
    end
  end

  // Accumulate and drain-clear live in disjoint states.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NEURON_COUNT; i++) begin
        ex_bank[i] <= '0;
        in_bank[i] <= '0;
      end
    end else if (syn_fire && addr_ok) begin
      if (SynInhibitory)
        in_bank[SynNeuronAddr] <= upd;
      else
        ex_bank[SynNeuronAddr] <= upd;
    end else if (sum_fire) begin
      ex_bank[idx] <= '0;
      in_bank[idx] <= '0;
    end
  end

  always_comb begin
    SumNeuronAddr = '0;
    ExWeightSum   = '0;
    InWeightSum   = '0;
    if (state == DRAIN) begin
      SumNeuronAddr = idx;
      ExWeightSum   = ex_bank[idx];
      InWeightSum   = in_bank[idx];
    end
  end

endmodule

// File: tb/tb_synaptic_weight_accumulator.sv
// Directed and randomized bench for synaptic_weight_accumulator,
// checked against a saturating-arithmetic model of the two sum banks.
module tb_synaptic_weight_accumulator;

  localparam longint SMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint SMIN = 64'sh8000_0000_0000_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        SynValid = 1'b0;
  logic        SynReady;
  logic [1:0]  SynNeuronAddr = '0;
  logic        SynInhibitory = 1'b0;
  logic [63:0] SynWeight = '0;
  logic        StepStart = 1'b0;
  logic        SumValid;
  logic        SumReady = 1'b0;
  logic [1:0]  SumNeuronAddr;
  logic [63:0] ExWeightSum;
  logic [63:0] InWeightSum;
  logic        StepDone;

  int tests = 0;
  int fails = 0;

  longint ex_m [4];
  longint in_m [4];

  synaptic_weight_accumulator dut (
    .Clock(Clock),
    .Reset(Reset),
    .SynValid(SynValid),
    .SynReady(SynReady),
    .SynNeuronAddr(SynNeuronAddr),
    .SynInhibitory(SynInhibitory),
    .SynWeight(SynWeight),
    .StepStart(StepStart),
    .SumValid(SumValid),
    .SumReady(SumReady),
    .SumNeuronAddr(SumNeuronAddr),
    .ExWeightSum(ExWeightSum),
    .InWeightSum(InWeightSum),
    .StepDone(StepDone)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint a, input longint b);
    if (b > 0 && a > SMAX - b) return SMAX;
    if (b < 0 && a < SMIN - b) return SMIN;
    return a + b;
  endfunction

  function automatic void model_add(input int a, input bit inh,
                                    input longint w);
    if (inh) in_m[a] = sat(in_m[a], w);
    else     ex_m[a] = sat(ex_m[a], w);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      ex_m[i] = 0;
      in_m[i] = 0;
    end
  endfunction

  task automatic send(input int a, input bit inh, input longint w);
    @(negedge Clock);
    SynValid = 1'b1;
    SynNeuronAddr = a[1:0];
    SynInhibitory = inh;
    SynWeight = w;
    #1 chk("syn_ready", SynReady, 1);
    model_add(a, inh, w);
    @(posedge Clock);
    #1 SynValid = 1'b0;
  endtask

  task automatic drain(input bit ev, input int ea, input bit einh,
                       input longint ew, input int stall_at,
                       input int start_at, input int reset_at);
    @(negedge Clock);
    StepStart = 1'b1;
    SumReady = 1'b1;
    if (ev) begin
      SynValid = 1'b1;
      SynNeuronAddr = ea[1:0];
      SynInhibitory = einh;
      SynWeight = ew;
      model_add(ea, einh, ew);
    end
    @(posedge Clock);
    #1;
    StepStart = 1'b0;
    SynValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", SumValid, 1);
      chk("drain_addr", SumNeuronAddr, i);
      chk("drain_ex", ExWeightSum, ex_m[i]);
      chk("drain_in", InWeightSum, in_m[i]);
      chk("drain_synready", SynReady, 0);
      chk("drain_done", StepDone, 0);
      if (i == reset_at) begin
        Reset = 1'b1;
        #1;
        chk("rst_valid", SumValid, 0);
        chk("rst_ex", ExWeightSum, 0);
        chk("rst_addr", SumNeuronAddr, 0);
        model_clear();
        @(negedge Clock);
        Reset = 1'b0;
        return;
      end
      if (i == stall_at) begin
        SumReady = 1'b0;
        SynValid = 1'b1;
        SynNeuronAddr = 2'd3;
        SynInhibitory = 1'b0;
        SynWeight = 64'h0000_0001_0000_0000;
        repeat (3) begin
          @(posedge Clock);
          #1;
          chk("stall_valid", SumValid, 1);
          chk("stall_addr", SumNeuronAddr, i);
          chk("stall_ex", ExWeightSum, ex_m[i]);
          chk("stall_in", InWeightSum, in_m[i]);
          chk("stall_synready", SynReady, 0);
        end
        SynValid = 1'b0;
        SumReady = 1'b1;
      end
      if (i == start_at) StepStart = 1'b1;
      @(posedge Clock);
      #1 StepStart = 1'b0;
    end
    chk("done_pulse", StepDone, 1);
    chk("done_valid", SumValid, 0);
    chk("done_synready", SynReady, 0);
    chk("done_ex", ExWeightSum, 0);
    model_clear();
    @(posedge Clock);
    #1;
    chk("after_done", StepDone, 0);
    chk("after_valid", SumValid, 0);
    chk("after_synready", SynReady, 1);
    @(posedge Clock);
    #1 chk("no_extra_drain", SumValid, 0);
    SumReady = 1'b0;
  endtask

  initial begin
    model_clear();
    #12;
    chk("reset_valid", SumValid, 0);
    chk("reset_done", StepDone, 0);
    chk("reset_addr", SumNeuronAddr, 0);
    chk("reset_ex", ExWeightSum, 0);
    chk("reset_in", InWeightSum, 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1 chk("reset_synready", SynReady, 1);

    // 1: empty step
    drain(0, 0, 0, 0, -1, -1, -1);

    // 2: fractional sums on neuron 2
    send(2, 0, 64'sh0000_0001_8000_0000);
    send(2, 0, 64'sh0000_0001_8000_0000);
    send(2, 0, -64'sh0000_0000_4000_0000);
    send(2, 1, 64'sh0000_0003_0000_0000);
    drain(0, 0, 0, 0, -1, -1, -1);

    // 3: saturation both directions
    send(0, 0, 64'sh7FFF_FFFF_0000_0000);
    send(0, 0, 64'sh0000_0002_0000_0000);
    send(1, 1, 64'sh8000_0001_0000_0000);
    send(1, 1, -64'sh0000_0002_0000_0000);
    drain(0, 0, 0, 0, -1, -1, -1);

    // 4: stall on addr 1, rejected event, then empty step
    send(1, 0, 64'sh0000_0005_0000_0000);
    send(1, 1, -64'sh0000_0001_0000_0000);
    drain(0, 0, 0, 0, 1, -1, -1);
    drain(0, 0, 0, 0, -1, -1, -1);

    // 5: event on StepStart edge; StepStart during drain
    send(3, 0, 64'sh0000_0000_1000_0000);
    drain(1, 3, 0, 64'sh0000_0000_2000_0000, -1, 1, -1);

    // 6: reset mid-drain, then zeros from addr 0
    send(2, 0, 64'sh0000_0007_0000_0000);
    send(3, 1, 64'sh0000_0001_0000_0000);
    drain(0, 0, 0, 0, -1, -1, 2);
    drain(0, 0, 0, 0, -1, -1, -1);

    // randomized steps
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(3, 12));
      for (int k = 0; k < n; k++) begin
        longint w;
        if ($urandom_range(0, 3) == 0)
          w = longint'({$urandom, $urandom});
        else
          w = longint'($signed($urandom_range(0, 32'h0010_0000)))
              - 64'sh0008_0000;
        w = (w <<< (($urandom_range(0, 3) == 0) ? 0 : 16));
        send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), w);
      end
      drain(1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            longint'({$urandom, $urandom}),
            (r % 3 == 0) ? int'($urandom_range(0, 3)) : -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
